// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch/run-control stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_W_DEF  = 10;
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: halt hold, absolute jump, relative branch, sequential.
module pc_next #(
  parameter int unsigned PC_W = 10
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            halt_i,
  input  logic            branch_abs_i,
  input  logic            branch_rel_i,
  input  logic            taken_i,
  input  logic [PC_W-1:0] target_i,
  input  logic [7:0]      offset_i,
  output logic [PC_W-1:0] next_pc_o
);

  localparam int unsigned EW = PC_W + 8;

  logic [EW-1:0] rel_sum;

  // Widen both operands so the signed offset extends correctly for any PC_W >= 8.
  assign rel_sum = EW'(pc_i) + EW'(signed'(offset_i));

  always_comb begin
    next_pc_o = pc_i + PC_W'(1);
    if (halt_i) begin
      next_pc_o = pc_i;
    end else if (branch_abs_i && taken_i) begin
      next_pc_o = target_i;
    end else if (branch_rel_i && taken_i) begin
      next_pc_o = rel_sum[PC_W-1:0];
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Run-control state machine, program counter, executed-cycle counter and done flag.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             BranchAbs,
  input  logic             BranchRel,
  input  logic             Taken,
  input  logic [PC_W-1:0]  Target,
  input  logic [7:0]       Offset,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Run,
  output logic             Ack,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  fetch_state_e     state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_q;

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc_i         (pc_q),
    .halt_i       (Halt),
    .branch_abs_i (BranchAbs),
    .branch_rel_i (BranchRel),
    .taken_i      (Taken),
    .target_i     (Target),
    .offset_i     (Offset),
    .next_pc_o    (pc_d)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pc_q <= START_PC;
          if (Start) state_q <= ARMED;
        end
        ARMED: begin
          pc_q  <= START_PC;
          cnt_q <= '0;
          if (!Start) state_q <= RUN;
        end
        RUN: begin
          // The HALT cycle itself is counted; the PC mux already holds on Halt.
          pc_q <= pc_d;
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          if (Halt) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
          end
        end
        DONE: begin
          if (Start) begin
            state_q <= ARMED;
            ack_q   <= 1'b0;
            pc_q    <= START_PC;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ProgCtr    = pc_q;
  assign Run        = (state_q == RUN);
  assign Ack        = ack_q;
  assign CycleCount = cnt_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and run-control stage for the single-cycle processor, sitting directly upstream of the instruction ROM inside TopLevel. It turns the Start/Reset request protocol into a running program, computes the next program counter each cycle (sequential, absolute jump, relative branch), gates architectural writes while idle, and raises Ack when the program executes its halt instruction. It drives the instruction ROM address and the done flag.

## Interface
- PC_W, 10: program counter width; the instruction ROM holds 2^PC_W 9-bit words.
- START_ADDR, 0: PC value loaded on reset and on every program (re)start.
- CNT_W, 16: width of the executed-cycle counter.

- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  run request from the bench/host; the program is launched by a high-then-low pulse.
- Halt  in  1  decoder: the current instruction is HALT.
- BranchAbs  in  1  decoder: the current instruction is an absolute jump.
- BranchRel  in  1  decoder: the current instruction is a relative branch.
- Taken  in  1  branch condition from the ALU flag (JNEQ etc.); unconditional jumps tie this high.
- Target  in  PC_W  absolute jump target from the immediate LUT.
- Offset  in  8  signed two's-complement relative branch offset.
- ProgCtr  out  PC_W  current PC, registered; drives the instruction ROM address.
- Run  out  1  high only in RUN; downstream gates RegWrite/MemWrite with it.
- Ack  out  1  registered program-done flag.
- CycleCount  out  CNT_W  number of RUN cycles executed in the current program.

## Operation
- States: IDLE, ARMED, RUN, DONE.
- Reset in any state, including mid-RUN: state IDLE, ProgCtr=START_ADDR, Ack=0, CycleCount=0. Run is 0 because state is IDLE.
- IDLE: PC held at START_ADDR. Start=1 moves to ARMED.
- ARMED: PC forced to START_ADDR and CycleCount cleared every cycle. Start=0 moves to RUN.
- RUN: Run=1; CycleCount increments each cycle and saturates at all-ones. Next PC priority:
  - Halt: hold PC; go to DONE.
  - BranchAbs & Taken: Target.
  - BranchRel & Taken: PC + sign-extended Offset, modulo 2^PC_W.
  - Otherwise: PC+1, modulo 2^PC_W.
- Branch control in RUN:
  - BranchAbs and BranchRel both asserted: absolute wins.
  - Halt beats any branch.
  - Taken=0: both branch inputs are ignored.
- DONE: Ack=1; PC and CycleCount held; Run=0. Start=1 moves to ARMED and Ack clears on that edge.
- Start=1 while in RUN is ignored. Only Reset aborts a running program.
- Wrap-around: the PC at 2^PC_W-1 with sequential fetch goes to 0. Relative branches wrap in both directions.

## Timing
- ProgCtr is a register; the instruction for a PC is valid combinationally in the same cycle as that PC.
- Start launch latency:
  - Start sampled 1 at edge N: ARMED from N.
  - Start sampled 0 at edge M>N: RUN from M, with the first instruction at START_ADDR in cycle M..M+1.
- Halt sampled at edge K: state DONE and Ack=1 from edge K. The HALT cycle itself has Run=1 and is counted.
- Branch taken at edge K: the target instruction is fetched in cycle K..K+1. There are no delay slots or bubbles.
- Run is decoded from the state register only, with no dependence on inputs. Ack is a flop.

## Structure
- Package fetch_pkg: state enum typedef (IDLE, ARMED, RUN, DONE), default PC_W and CNT_W constants.
- Sub-module pc_next: a purely combinational next-PC mux (inputs: PC, Halt, branch controls, Taken, Target, Offset). It is instantiated once in fetch_sequencer; the state machine, PC register, counter and Ack live in the parent.

## Test plan
- Reset, then Start 1 for 2 cycles, then 0, with no branches -> ProgCtr=0,1,2,3 on successive edges; Run=1 from the first RUN cycle; Ack=0.
- In RUN at PC=5: BranchAbs=1, Taken=1, Target=40 -> ProgCtr=40 next edge. Repeat with Taken=0 -> ProgCtr=6.
- At PC=20: BranchRel=1, Taken=1, Offset=-4 -> 16. At PC=1023 (PC_W=10) with sequential fetch -> 0. At PC=2 with Offset=-5 -> 1021.
- At PC=9: Halt=1 together with BranchAbs=1 and Taken=1 -> ProgCtr stays 9, Ack=1 next edge, Run=0. With a 10-cycle program, CycleCount=10. Later Start pulse -> ProgCtr=0, Ack=0, CycleCount=0.
- Reset asserted mid-RUN at PC=30 -> next edge ProgCtr=0, Ack=0, Run=0, state IDLE. Start held at 1 throughout -> remains ARMED, PC=0, no instructions executed.
